cordic_sequencer: RTL and testbench

- Iteration controller for the CORDIC core. It sequences the arctan/arctanh angle LUT and the shift/add datapath, one micro-rotation per cycle.
- Drives LUT offset and system select, the datapath shift amount and per-iteration strobes.
- Inserts the hyperbolic repeat iterations (4 and 13) and handles start/done handshake, stall and abort.
- Sits between the accelerator's command/register front-end and the lut + rotation datapath.

---
 rtl/cordic_sequencer.sv | 154 +++++++++++++++
 tb/tb_cordic_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sequencer.sv
// CORDIC iteration controller: walks the angle LUT one micro-rotation per cycle,
// inserts the hyperbolic repeat iterations and runs the start/done handshake.
module cordic_sequencer #(
    parameter int unsigned p_ANGLE_ADDR_WIDTH = 5,
    parameter int unsigned p_CNT_WIDTH        = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          startSystem,
    input  logic [p_CNT_WIDTH-1:0]        numIter,
    input  logic                          stall,
    input  logic                          abort,
    output logic                          busy,
    output logic [p_ANGLE_ADDR_WIDTH-1:0] lutOffset,
    output logic                          lutSystem,
    output logic [p_ANGLE_ADDR_WIDTH-1:0] shiftAmt,
    output logic                          iterValid,
    output logic                          firstIter,
    output logic                          lastIter,
    output logic                          done,
    output logic                          aborted
);

    localparam int unsigned AW = p_ANGLE_ADDR_WIDTH;
    localparam int unsigned CW = p_CNT_WIDTH;

    localparam logic [AW-1:0] OffOne  = AW'(1);
    localparam logic [AW-1:0] OffMax  = '1;
    localparam logic [AW-1:0] OffRepA = AW'(4);
    localparam logic [AW-1:0] OffRepB = AW'(13);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic            sys_q;
    logic [CW-1:0]   num_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   off_q;
    logic            rep_q;
    logic            busy_q;
    logic            valid_q;
    logic            first_q;
    logic            last_q;
    logic            done_q;
    logic            aborted_q;

    logic            hold_d;
    logic [AW-1:0]   off_d;
    logic [CW-1:0]   cnt_d;
    logic [AW-1:0]   start_off;

    // Hyperbolic offsets 4 and 13 are issued a second time before advancing.
    function automatic logic rep_pending(input logic sys, input logic [AW-1:0] off,
                                         input logic rep);
        return !sys && !rep && (off == OffRepA || off == OffRepB);
    endfunction

    // Last iteration: requested count reached, or LUT exhausted with no repeat left.
    function automatic logic is_last(input logic [CW-1:0] num, input logic sys,
                                     input logic [CW-1:0] cnt, input logic [AW-1:0] off,
                                     input logic rep);
        return (cnt == (num - CntOne)) || (off == OffMax && !rep_pending(sys, off, rep));
    endfunction

    // Position of the next iteration once the current one completes.
    always_comb begin
        hold_d    = rep_pending(sys_q, off_q, rep_q);
        off_d     = hold_d ? off_q : off_q + OffOne;
        cnt_d     = cnt_q + CntOne;
        start_off = startSystem ? '0 : OffOne;
    end

    // Sequencer FSM; every output comes straight from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sys_q     <= 1'b0;
            num_q     <= '0;
            cnt_q     <= '0;
            off_q     <= '0;
            rep_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q    <= 1'b0;
                    aborted_q <= 1'b0;
                    if (start) begin
                        sys_q <= startSystem;
                        num_q <= numIter;
                        cnt_q <= '0;
                        rep_q <= 1'b0;
                        off_q <= start_off;
                        if (numIter == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                            valid_q <= !stall;
                            first_q <= 1'b1;
                            last_q  <= is_last(numIter, startSystem, '0, start_off, 1'b0);
                        end
                    end
                end
                StRun: begin
                    if (abort || (valid_q && last_q)) begin
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                        aborted_q <= abort;
                        busy_q    <= 1'b0;
                        valid_q   <= 1'b0;
                        first_q   <= 1'b0;
                        last_q    <= 1'b0;
                    end else if (valid_q) begin
                        cnt_q   <= cnt_d;
                        off_q   <= off_d;
                        rep_q   <= hold_d;
                        valid_q <= !stall;
                        first_q <= 1'b0;
                        last_q  <= is_last(num_q, sys_q, cnt_d, off_d, hold_d);
                    end else begin
                        // Stalled: offset and qualifiers hold until the iteration issues.
                        valid_q <= !stall;
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    done_q    <= 1'b0;
                    aborted_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign lutOffset = off_q;
    assign shiftAmt  = off_q;
    assign lutSystem = sys_q;
    assign iterValid = valid_q;
    assign firstIter = first_q;
    assign lastIter  = last_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: directed table plus randomized jobs
// compared against an offset-list model of a job.
module tb_cordic_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       startSystem = 1'b0;
    logic [5:0] numIter = '0;
    logic       stall = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic [4:0] lutOffset;
    logic       lutSystem;
    logic [4:0] shiftAmt;
    logic       iterValid;
    logic       firstIter;
    logic       lastIter;
    logic       done;
    logic       aborted;

    int checks = 0;
    int errors = 0;

    cordic_sequencer #(
        .p_ANGLE_ADDR_WIDTH(5),
        .p_CNT_WIDTH       (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .startSystem(startSystem),
        .numIter    (numIter),
        .stall      (stall),
        .abort      (abort),
        .busy       (busy),
        .lutOffset  (lutOffset),
        .lutSystem  (lutSystem),
        .shiftAmt   (shiftAmt),
        .iterValid  (iterValid),
        .firstIter  (firstIter),
        .lastIter   (lastIter),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " iterValid"}, int'(iterValid), 0);
        chk({tag, " lutOffset"}, int'(lutOffset), 0);
        chk({tag, " shiftAmt"}, int'(shiftAmt), 0);
        chk({tag, " lutSystem"}, int'(lutSystem), 0);
        chk({tag, " firstIter"}, int'(firstIter), 0);
        chk({tag, " lastIter"}, int'(lastIter), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " aborted"}, int'(aborted), 0);
    endtask

    // Offsets a job issues: circular 0..31, hyperbolic 1..31 with 4 and 13 doubled,
    // truncated to the requested count.
    task automatic build_list(input bit sys, input int num, output int q[$]);
        q = {};
        for (int o = (sys ? 0 : 1); o < 32; o++) begin
            q.push_back(o);
            if (!sys && (o == 4 || o == 13)) q.push_back(o);
        end
        while (q.size() > num) void'(q.pop_back());
    endtask

    // Runs one job from IDLE (called at a negedge) and checks every cycle.
    // mode: 0 no stall, 1 stall three cycles holding offset index 2, 2 random stall.
    task automatic run_job(input bit sys, input int num, input int mode, input int abort_at,
                           output int iters, output int lat);
        int  q[$];
        int  len;
        int  idx;
        int  scnt;
        bit  prev_stall;
        bit  exp_v;
        bit  aborting;
        build_list(sys, num, q);
        len      = q.size();
        idx      = 0;
        scnt     = 0;
        iters    = 0;
        aborting = 0;
        start       = 1'b1;
        startSystem = sys;
        numIter     = 6'(num);
        abort       = 1'($urandom_range(0, 1));  // start must win over abort in IDLE
        stall       = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_stall  = stall;
        step();
        lat   = 1;
        start = 1'b0;
        abort = 1'b0;
        if (len > 0) begin
            while (1) begin
                if (lat > 300) begin
                    chk("job timeout", lat, 0);
                    break;
                end
                exp_v = !prev_stall;
                chk("run busy", int'(busy), 1);
                chk("run iterValid", int'(iterValid), int'(exp_v));
                chk("run lutOffset", int'(lutOffset), q[idx]);
                chk("run shiftAmt", int'(shiftAmt), q[idx]);
                chk("run lutSystem", int'(lutSystem), int'(sys));
                chk("run firstIter", int'(firstIter), int'(idx == 0));
                chk("run lastIter", int'(lastIter), int'(idx == len - 1));
                chk("run done", int'(done), 0);
                if (exp_v) iters++;
                if (abort_at >= 0 && idx == abort_at) begin
                    aborting = 1;
                    abort    = 1'b1;
                end else if (exp_v) begin
                    idx++;
                end
                // Inputs that must not disturb a running job.
                start       = 1'($urandom_range(0, 1));
                startSystem = 1'($urandom_range(0, 1));
                numIter     = 6'($urandom_range(0, 63));
                if (mode == 1) begin
                    stall = (idx == 2 && scnt < 3) ? 1'b1 : 1'b0;
                    if (stall) scnt++;
                end else if (mode == 2 || aborting) begin
                    stall = 1'($urandom_range(0, 1));
                end else begin
                    stall = 1'b0;
                end
                prev_stall = stall;
                step();
                lat++;
                abort = 1'b0;
                if (aborting || idx == len) break;
            end
        end
        // DONE cycle; start and abort here must be ignored.
        chk("done pulse", int'(done), 1);
        chk("done aborted", int'(aborted), int'(aborting));
        chk("done busy", int'(busy), 0);
        chk("done iterValid", int'(iterValid), 0);
        start       = 1'b1;
        startSystem = 1'($urandom_range(0, 1));
        numIter     = 6'd5;
        abort       = 1'($urandom_range(0, 1));
        stall       = 1'b0;
        step();
        chk("idle done", int'(done), 0);
        chk("idle busy", int'(busy), 0);
        chk("idle aborted", int'(aborted), 0);
        chk("idle iterValid", int'(iterValid), 0);
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct {
        bit sys;
        int num;
        int mode;
        int abort_at;
        int exp_iters;
        int exp_lat;
    } vec_t;

    initial begin
        vec_t tbl[9];
        int   iters;
        int   lat;
        int   len;
        int   ab;
        int   q[$];

        tbl[0] = '{1'b1, 16, 0, -1, 16, 17};
        tbl[1] = '{1'b0, 15, 0, -1, 15, 16};
        tbl[2] = '{1'b1,  4, 1, -1,  4,  8};
        tbl[3] = '{1'b1, 40, 0, -1, 32, 33};
        tbl[4] = '{1'b0, 40, 0, -1, 33, 34};
        tbl[5] = '{1'b1,  0, 0, -1,  0,  1};
        tbl[6] = '{1'b1, 16, 0,  5,  6,  7};
        tbl[7] = '{1'b1, 16, 0, -1, 16, 17};
        tbl[8] = '{1'b0,  1, 0, -1,  1,  2};

        // Reset state.
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("idle");

        foreach (tbl[i]) begin
            run_job(tbl[i].sys, tbl[i].num, tbl[i].mode, tbl[i].abort_at, iters, lat);
            chk($sformatf("vec%0d iters", i), iters, tbl[i].exp_iters);
            chk($sformatf("vec%0d latency", i), lat, tbl[i].exp_lat);
        end

        // Asynchronous reset while running at offset 7.
        start       = 1'b1;
        startSystem = 1'b1;
        numIter     = 6'd16;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("pre-reset offset", int'(lutOffset), 7);
        chk("pre-reset busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        step();
        chk("reset done", int'(done), 0);
        rst = 1'b0;
        step();
        chk("post-reset done", int'(done), 0);
        run_job(1'b1, 8, 0, -1, iters, lat);
        chk("post-reset iters", iters, 8);
        chk("post-reset latency", lat, 9);

        // Randomized jobs against the offset-list model.
        for (int n = 0; n < 25; n++) begin
            bit sys;
            int num;
            sys = 1'($urandom_range(0, 1));
            num = $urandom_range(0, 45);
            build_list(sys, num, q);
            len = q.size();
            ab  = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            run_job(sys, num, 2, ab, iters, lat);
            if (ab < 0) chk($sformatf("rand%0d iters", n), iters, len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
